// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer.
package mdu_pkg;

    // Op codes shared with the ALU ALU_OPERATION field.
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    localparam logic [31:0] MIN_INT  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    function automatic logic is_m_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the execute stage and the MDU sequencer.
interface mdu_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            START;
    logic [4:0]      ALU_OPERATION;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic            FLUSH;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, ALU_OPERATION, DATA1, DATA2, FLUSH,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, ALU_OPERATION, DATA1, DATA2, FLUSH,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/mdu_div_core.sv
// Restoring shift/subtract divider on operand magnitudes; sign fix-up is
// applied combinationally on the outputs while fix_i is high.
module mdu_div_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Load magnitudes or perform one shift/trial-subtract iteration.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvs_q};
        if (load_i) begin
            neg_rem_d = signed_i & dividend_i[XLEN-1];
            neg_quo_d = signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
            quo_d     = (signed_i & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
            dvs_d     = (signed_i & divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
            rem_d     = '0;
        end else if (step_i) begin
            // A clear top bit means the shifted remainder covered the divisor.
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Signed results: quotient negative when signs differ, remainder follows dividend.
    always_comb begin
        quotient_o  = (fix_i && neg_quo_q) ? -quo_q : quo_q;
        remainder_o = (fix_i && neg_rem_q) ? -rem_q : rem_q;
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV/REM controller for the RV32IM execute stage.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic          CLK,
    input  logic          RESET_N,
    mdu_sequencer_if.slave bus
);

    localparam logic [XLEN-1:0] MIN_V = XLEN'(MIN_INT >> (32 - XLEN));
    localparam logic [XLEN-1:0] ALL_V = XLEN'(ALL_ONES >> (32 - XLEN));

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              in_div, in_sdiv, in_rem, special;
    logic [XLEN-1:0]   special_res;
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] prod;
    logic              div_load, div_step, div_fix;
    logic [XLEN-1:0]   div_quo, div_rem;

    mdu_div_core #(.XLEN(XLEN)) u_div (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .load_i      (div_load),
        .step_i      (div_step),
        .fix_i       (div_fix),
        .signed_i    (in_sdiv),
        .dividend_i  (bus.DATA1),
        .divisor_i   (bus.DATA2),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Request decode and divide special cases resolved at acceptance.
    always_comb begin
        accept  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.START
                  && !bus.FLUSH && is_m_op(bus.ALU_OPERATION);
        in_div  = bus.ALU_OPERATION >= OP_DIV;
        in_sdiv = (bus.ALU_OPERATION == OP_DIV) || (bus.ALU_OPERATION == OP_REM);
        in_rem  = (bus.ALU_OPERATION == OP_REM) || (bus.ALU_OPERATION == OP_REMU);
        special = in_div && ((bus.DATA2 == '0)
                  || (in_sdiv && (bus.DATA1 == MIN_V) && (bus.DATA2 == ALL_V)));
        if (bus.DATA2 == '0) begin
            special_res = in_rem ? bus.DATA1 : ALL_V;
        end else begin
            special_res = in_rem ? '0 : MIN_V;
        end
    end

    // Product of the latched operands, sign-extended to full width per op.
    always_comb begin
        a_sgn = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[XLEN-1];
        b_sgn = (op_q == OP_MULH) & b_q[XLEN-1];
        prod  = {{XLEN{a_sgn}}, a_q} * {{XLEN{b_sgn}}, b_q};
    end

    // State, counter, operand and result registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    // Next-state, divider controls and result capture on entry to DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        div_load = 1'b0;
        div_step = 1'b0;
        div_fix  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    a_d  = bus.DATA1;
                    b_d  = bus.DATA2;
                    op_d = bus.ALU_OPERATION;
                    if (special) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                    end else if (in_div) begin
                        state_d  = ST_DIV;
                        cnt_d    = CNT_W'(XLEN - 1);
                        div_load = 1'b1;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                state_d  = ST_DONE;
                result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                div_fix  = 1'b1;
                state_d  = ST_DONE;
                result_d = ((op_q == OP_REM) || (op_q == OP_REMU)) ? div_rem : div_quo;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.FLUSH) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            div_step = 1'b0;
            div_fix  = 1'b0;
        end
    end

    // Status outputs decoded from the registered state only.
    always_comb begin
        bus.BUSY   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
        bus.DONE   = (state_q == ST_DONE);
        bus.RESULT = result_q;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle controller for the M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) of the RV32IM execute stage. It latches operands on a START request and holds BUSY so the pipeline stalls. MUL-class ops complete in 2 cycles. Non-special divide/remainder ops run a 32-iteration restoring divider. It returns a one-cycle DONE pulse with RESULT, using the same 5-bit ALU_OPERATION encoding the ALU uses.

Parameters:
XLEN, 32, operand/result width; fixed at 32 for RV32, parameterised only for bench shrinking.
CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
CLK  in  1  clock, rising-edge.
RESET_N  in  1  asynchronous, active-low reset.
START  in  1  request; sampled only when the sequencer is idle.
ALU_OPERATION  in  5  op code. MUL=01010, MULH=01011, MULHSU=01100, MULHU=01101, DIV=01110, DIVU=01111, REM=10000, REMU=10001.
DATA1  in  XLEN  rs1 operand (dividend / multiplicand).
DATA2  in  XLEN  rs2 operand (divisor / multiplier).
FLUSH  in  1  synchronous abort from branch/hazard unit.
BUSY  out  1  high while an op is in flight; pipeline stall.
DONE  out  1  one-cycle pulse when RESULT is valid.
RESULT  out  XLEN  result; held until the next DONE.

Behaviour:
- Reset (RESET_N low, asynchronous): state=IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, operand registers=0. Reset takes effect immediately, mid-operation included. The in-flight op is lost.
- States: IDLE, MUL, DIV, FIX, DONE.
- A START is accepted only when the state is IDLE or DONE, START=1, FLUSH=0, and ALU_OPERATION is in 01010..10001. On acceptance, DATA1, DATA2 and the op are latched at that edge (cycle N).
- START with any other op code: ignored; no BUSY, no DONE.
- START while BUSY=1: ignored; operands are not re-latched.
- MUL path: IDLE -> MUL (N+1) -> DONE (N+2).
  - MUL state: 64-bit product formed from the latched operands and registered.
  - MUL returns low 32 bits. MULH uses signed x signed. MULHSU uses signed DATA1 x unsigned DATA2. MULHU uses unsigned x unsigned. MULH/MULHSU/MULHU return the high 32 bits.
- Special divide cases are resolved at acceptance and go directly to DONE at N+1:
  - Divisor == 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> DATA1.
  - Signed overflow (DIV/REM with DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Normal divide path: IDLE -> DIV for 32 cycles (N+1..N+32, counter 31 down to 0) -> FIX (N+33) -> DONE (N+34).
  - Signed ops divide magnitudes.
  - Each DIV cycle: shift {rem,quo} left 1; trial-subtract |divisor|; set quotient bit if non-negative.
  - FIX: negate quotient if operand signs differ; negate remainder if dividend is negative (remainder takes the sign of the dividend).
- DONE state: DONE=1 for exactly one cycle; RESULT is updated on entry; BUSY=0. A new START is accepted in this cycle (back-to-back); otherwise the next state is IDLE.
- BUSY = 1 in the MUL, DIV and FIX states only. It rises at N+1; no combinational path from START.
- FLUSH=1 in any state: next state IDLE, no DONE, RESULT unchanged, counter cleared. FLUSH and START in the same cycle: FLUSH wins; START is dropped.
- RESULT changes only on entry to DONE; stable at all other times.

Decomposition:
- Package mdu_pkg:
  - localparams for the eight M op codes, matching the ALU encoding.
  - state encoding.
  - helper constants MIN_INT=0x80000000 and ALL_ONES.
- Sub-module mdu_div_core: restoring shift/subtract datapath with load, step and fix controls. It exposes quotient and remainder.
- mdu_sequencer holds the FSM, counter, operand latches, multiplier and special-case logic.

Test Plan:
1. MUL 0x10 x 0x10, START at N -> BUSY high at N+1, DONE pulse at N+2, RESULT=0x00000100.
2. DATA1=0x80000000, DATA2=0x2 -> MULH=0xFFFFFFFF, MULHSU=0xFFFFFFFF, MULHU=0x00000001, MUL=0x00000000; each DONE at N+2.
3. Normal divides, each with DONE at N+34:
   - DIV 0x10/0x2 -> 0x00000008.
   - DIVU 0x10/0x2 -> 0x00000008.
   - REM 0x11,0x2 -> 0x00000001.
   - DIV 0xFFFFFFF9/0x2 -> 0xFFFFFFFD.
   - REM 0xFFFFFFF9,0x2 -> 0xFFFFFFFF.
   - Back-to-back START in the DONE cycle accepted.
4. Special cases, each with DONE at N+1 and no BUSY:
   - DIV 0x1234/0 -> 0xFFFFFFFF.
   - REMU 0x1234/0 -> 0x00001234.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000,0xFFFFFFFF -> 0x00000000.
5. FLUSH during DIV at N+10 -> IDLE at N+11, BUSY=0, no DONE, RESULT holds its prior value. A fresh MUL then completes normally.
6. RESET_N low at N+5 of a DIV -> BUSY/DONE/RESULT=0 immediately, no DONE after release. START with op 00010 (ADD) -> ignored. START while BUSY -> ignored; the first op's result is returned.
